mux_gate_classifier: RTL and testbench

- Sequential inverse of the mux-built gate library. It drives the two inputs of a gate-under-test (GUT) through all four {a,b} vectors and captures the single response bit for each.
- From the responses it reconstructs the 4-bit truth table and identifies the gate: INV, AND, OR, NAND, NOR, XOR or XNOR.
- Used as a self-check/characterisation block beside mux-gate instances, and in bring-up benches.

---
 rtl/mux_gate_classifier.sv | 148 ++++++++++++++
 tb/tb_mux_gate_classifier.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_gate_classifier.sv
// Drives a 2-input gate-under-test through every {a,b} vector, rebuilds its
// truth table over one or more passes and names the gate it found.
module mux_gate_classifier #(
  parameter int SETTLE = 2,
  parameter int PASSES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       drv_a,
  output logic       drv_b,
  input  logic       resp,
  output logic [3:0] truth,
  output logic [2:0] gate_id,
  output logic       unstable
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(SETTLE - 1);
  localparam logic [PW-1:0] PASS_LAST = PW'(PASSES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] pass_q, pass_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          drv_a_q, drv_a_d;
  logic          drv_b_q, drv_b_d;
  logic [3:0]    truth_q, truth_d;
  logic [2:0]    gate_id_q, gate_id_d;
  logic          unstable_q, unstable_d;

  function automatic logic [2:0] decode(input logic [3:0] tt);
    case (tt)
      4'b1000: decode = 3'd1;
      4'b1110: decode = 3'd2;
      4'b0111: decode = 3'd3;
      4'b0001: decode = 3'd4;
      4'b0110: decode = 3'd5;
      4'b1001: decode = 3'd6;
      4'b0011: decode = 3'd7;
      default: decode = 3'd0;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    pass_d     = pass_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    drv_a_d    = drv_a_q;
    drv_b_d    = drv_b_q;
    truth_d    = truth_q;
    gate_id_d  = gate_id_q;
    unstable_d = unstable_q;
    case (state_q)
      // The done cycle behaves as idle so back-to-back runs need no gap.
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          state_d    = S_RUN;
          busy_d     = 1'b1;
          idx_d      = 2'd0;
          cnt_d      = '0;
          pass_d     = '0;
          drv_a_d    = 1'b0;
          drv_b_d    = 1'b0;
          truth_d    = 4'b0000;
          gate_id_d  = 3'd0;
          unstable_d = 1'b0;
        end
      end
      S_RUN: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          idx_d = idx_q + 2'd1;
          if (pass_q == '0) begin
            truth_d[idx_q] = resp;
          end else if (resp != truth_q[idx_q]) begin
            unstable_d = 1'b1;
          end
          {drv_a_d, drv_b_d} = idx_d;
          if (idx_q == 2'd3) begin
            pass_d = pass_q + 1'b1;
            if (pass_q == PASS_LAST) begin
              state_d   = S_DONE;
              busy_d    = 1'b0;
              done_d    = 1'b1;
              drv_a_d   = 1'b0;
              drv_b_d   = 1'b0;
              pass_d    = '0;
              // Decode from the just-updated table so the final sample counts.
              gate_id_d = unstable_d ? 3'd0 : decode(truth_d);
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= 2'd0;
      cnt_q      <= '0;
      pass_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      drv_a_q    <= 1'b0;
      drv_b_q    <= 1'b0;
      truth_q    <= 4'b0000;
      gate_id_q  <= 3'd0;
      unstable_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      pass_q     <= pass_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      drv_a_q    <= drv_a_d;
      drv_b_q    <= drv_b_d;
      truth_q    <= truth_d;
      gate_id_q  <= gate_id_d;
      unstable_q <= unstable_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign drv_a    = drv_a_q;
  assign drv_b    = drv_b_q;
  assign truth    = truth_q;
  assign gate_id  = gate_id_q;
  assign unstable = unstable_q;

endmodule

// File: tb/tb_mux_gate_classifier.sv
// Bench for mux_gate_classifier: a default instance and a SETTLE=1/PASSES=1
// instance, each checked every cycle against a timeline model of a run.
module tb_mux_gate_classifier;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_v[2];
  logic       busy_o[2];
  logic       done_o[2];
  logic       drv_a_o[2];
  logic       drv_b_o[2];
  logic       resp_v[2];
  logic [3:0] truth_o[2];
  logic [2:0] gate_o[2];
  logic       uns_o[2];

  logic [3:0] tt_live[2];
  bit         force_en[2];
  bit         force_now[2];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  assign resp_v[0] = tt_live[0][{drv_a_o[0], drv_b_o[0]}] & ~force_now[0];
  assign resp_v[1] = tt_live[1][{drv_a_o[1], drv_b_o[1]}] & ~force_now[1];

  mux_gate_classifier dut (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .busy(busy_o[0]),
    .done(done_o[0]), .drv_a(drv_a_o[0]), .drv_b(drv_b_o[0]),
    .resp(resp_v[0]), .truth(truth_o[0]), .gate_id(gate_o[0]),
    .unstable(uns_o[0])
  );

  mux_gate_classifier #(.SETTLE(1), .PASSES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .busy(busy_o[1]),
    .done(done_o[1]), .drv_a(drv_a_o[1]), .drv_b(drv_b_o[1]),
    .resp(resp_v[1]), .truth(truth_o[1]), .gate_id(gate_o[1]),
    .unstable(uns_o[1])
  );

  // Model: a run is a timeline t = edges since the accepting start edge.
  int         SS[2] = '{2, 1};
  int         PP[2] = '{2, 1};
  bit         mact[2];
  int         mt[2];
  logic [3:0] mtt[2];
  bit         mfrc[2];

  function automatic int run_len(input int k);
    return 4 * SS[k] * PP[k];
  endfunction

  function automatic logic rr(input logic [3:0] tt, input bit frc, input int j);
    logic b;
    b = tt[j % 4];
    if (frc && j >= 4) b = 1'b0;
    return b;
  endfunction

  function automatic logic [2:0] name_of(input logic [3:0] tt);
    logic [3:0] pat[7];
    pat = '{4'b1000, 4'b1110, 4'b0111, 4'b0001, 4'b0110, 4'b1001, 4'b0011};
    for (int i = 0; i < 7; i++) if (pat[i] == tt) return 3'(i + 1);
    return 3'd0;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        mact[k] = 1'b0;
        mt[k]   = 0;
      end else if ((!mact[k] || mt[k] >= run_len(k)) && start_v[k]) begin
        mact[k] = 1'b1;
        mt[k]   = 0;
        mtt[k]  = tt_live[k];
        mfrc[k] = force_en[k];
      end else if (mact[k] && mt[k] <= run_len(k)) begin
        mt[k] = mt[k] + 1;
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int n, s, t;
      logic [3:0] e_truth;
      bit e_uns;
      int e_gid, e_drv, e_busy, e_done;
      n = run_len(k);
      t = mt[k];
      e_truth = 4'b0000; e_uns = 1'b0; e_gid = 0; e_drv = 0; e_busy = 0; e_done = 0;
      if (mact[k]) begin
        s = ((t > n) ? n : t) / SS[k];
        for (int v = 0; v < 4; v++) if (s > v) e_truth[v] = rr(mtt[k], mfrc[k], v);
        for (int j = 4; j < s; j++)
          if (rr(mtt[k], mfrc[k], j) != rr(mtt[k], mfrc[k], j % 4)) e_uns = 1'b1;
        e_busy = (t < n) ? 1 : 0;
        e_done = (t == n) ? 1 : 0;
        e_drv  = (t < n) ? (t / SS[k]) % 4 : 0;
        e_gid  = (t >= n && !e_uns) ? int'(name_of(e_truth)) : 0;
      end
      chk($sformatf("busy%0d", k), busy_o[k], e_busy);
      chk($sformatf("done%0d", k), done_o[k], e_done);
      chk($sformatf("drv%0d", k), {drv_a_o[k], drv_b_o[k]}, e_drv);
      chk($sformatf("truth%0d", k), truth_o[k], e_truth);
      chk($sformatf("unstable%0d", k), uns_o[k], e_uns);
      chk($sformatf("gate_id%0d", k), gate_o[k], e_gid);
      force_now[k] = mact[k] && mfrc[k] && t >= 4 * SS[k] && t < n;
    end
  end

  task automatic pulse(input int k);
    @(negedge clk) start_v[k] = 1'b1;
    @(negedge clk) start_v[k] = 1'b0;
  endtask

  task automatic run(input int k, input logic [3:0] tt, input bit frc);
    tt_live[k]  = tt;
    force_en[k] = frc;
    pulse(k);
    repeat (run_len(k) + 3) @(negedge clk);
    $display("run dut%0d tt=%b force=%0d -> truth=%b gate_id=%0d unstable=%0d",
             k, tt, frc, truth_o[k], gate_o[k], uns_o[k]);
  endtask

  initial begin
    logic [3:0] sweep[8];
    int         sweep_id[8];
    start_v = '{1'b0, 1'b0};
    tt_live = '{4'b0000, 4'b0000};
    force_en = '{1'b0, 1'b0};
    force_now = '{1'b0, 1'b0};
    sweep    = '{4'b1110, 4'b0111, 4'b0001, 4'b0110, 4'b1001, 4'b0011, 4'b1111, 4'b0100};
    sweep_id = '{2, 3, 4, 5, 6, 7, 0, 0};
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;

    run(0, 4'b1000, 1'b0);
    chk("and_truth", truth_o[0], 4'b1000);
    chk("and_gate_id", gate_o[0], 1);
    for (int i = 0; i < 8; i++) begin
      run(0, sweep[i], 1'b0);
      chk($sformatf("sweep_gid_%b", sweep[i]), gate_o[0], sweep_id[i]);
      chk($sformatf("sweep_truth_%b", sweep[i]), truth_o[0], sweep[i]);
    end

    run(0, 4'b0110, 1'b1);
    chk("xor_forced_truth", truth_o[0], 4'b0110);
    chk("xor_forced_unstable", uns_o[0], 1);
    chk("xor_forced_gid", gate_o[0], 0);

    // Restart attempt mid-run, then a restart in the done cycle.
    tt_live[0] = 4'b1000; force_en[0] = 1'b0;
    pulse(0);
    repeat (3) @(negedge clk);
    pulse(0);
    repeat (10) @(negedge clk);
    pulse(0);
    repeat (20) @(negedge clk);
    $display("restart sequence: gate_id=%0d", gate_o[0]);

    // Reset mid-sweep.
    tt_live[0] = 4'b0001;
    pulse(0);
    repeat (6) @(negedge clk);
    @(posedge clk); #3 rst_n = 1'b0;
    #1 chk("rst_busy", busy_o[0], 0);
    chk("rst_truth", truth_o[0], 0);
    @(posedge clk); #3 rst_n = 1'b1;
    run(0, 4'b0001, 1'b0);
    chk("post_rst_gid", gate_o[0], 4);

    run(1, 4'b0001, 1'b0);
    chk("s1_nor_truth", truth_o[1], 4'b0001);
    chk("s1_nor_gid", gate_o[1], 4);
    run(1, 4'b0110, 1'b1);
    chk("s1_p1_unstable", uns_o[1], 0);

    for (int it = 0; it < 40; it++) begin
      int k;
      k = it % 2;
      tt_live[k]  = 4'($urandom_range(0, 15));
      force_en[k] = ($urandom_range(0, 3) == 0);
      pulse(k);
      repeat ($urandom_range(0, run_len(k) + 2)) @(negedge clk);
      if ($urandom_range(0, 1) == 1) pulse(k);
      repeat (run_len(k) + 3) @(negedge clk);
      $display("rand %0d dut%0d tt=%b force=%0d -> gate_id=%0d unstable=%0d",
               it, k, tt_live[k], force_en[k], gate_o[k], uns_o[k]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
